// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache.
// Loads that hit complete in the same cycle. Misses refill a 4-word line from
// the memory burst bus. Stores are forwarded one word at a time to memory.
// Optional feature macro: DCACHE_UNCACHED_WINDOW_EN. When it is defined,
// loads from 0xBxxx_xxxx bypass the arrays and use a single-beat read, and
// stores to that window never update the arrays.
module dcache_wt #(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic        ram_read_en,
  input  logic        ram_write_en,
  input  logic [3:0]  ram_select,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic        is_cache_hit,
  output logic [31:0] ram_read_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rlast,
  input  logic        mem_wdone
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL, RESP, WR_REQ, WR_WAIT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES][4];
  logic [LINES-1:0]   valid;
  logic [31:0]        fill_buf [4];
  logic [1:0]         beat;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word;
  logic               uncached;
  logic               hit;
  logic               is_store;
  logic               is_load;
  logic               fill_we;
  logic [1:0]         fill_idx;

  assign idx  = ram_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag  = ram_addr[31 -: TAG_W];
  assign word = ram_addr[3:2];

`ifdef DCACHE_UNCACHED_WINDOW_EN
  assign uncached = (ram_addr[31:28] == 4'hB);
`else
  assign uncached = 1'b0;
`endif

  // Uncached accesses never see a hit, so stores there also skip the merge.
  assign hit      = valid[idx] && (tag_mem[idx] == tag) && !uncached;
  // Store wins when both enables are set.
  assign is_store = ram_en && ram_write_en;
  assign is_load  = ram_en && ram_read_en && !ram_write_en;
  assign fill_we  = (state == REFILL) && mem_rvalid;
  // A single-beat uncached read lands where RESP will look for the word.
  assign fill_idx = uncached ? word : beat;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    is_cache_hit  = 1'b0;
    ram_read_data = 32'h0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_wstrb     = 4'h0;
    case (state)
      IDLE: begin
        if (is_store) begin
          state_nxt = WR_REQ;
        end else if (is_load) begin
          if (hit) begin
            is_cache_hit  = 1'b1;
            ram_read_data = data_mem[idx][word];
          end else begin
            state_nxt = REFILL_REQ;
          end
        end
      end
      REFILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = uncached ? {ram_addr[31:2], 2'b00} : {ram_addr[31:4], 4'b0000};
        if (mem_ack) state_nxt = REFILL;
      end
      REFILL: begin
        if (mem_rvalid && mem_rlast) state_nxt = RESP;
      end
      RESP: begin
        is_cache_hit  = 1'b1;
        ram_read_data = ram_write_en ? 32'h0 : fill_buf[word];
        state_nxt     = IDLE;
      end
      WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ram_addr;
        mem_wdata = ram_write_data;
        mem_wstrb = ram_select;
        if (mem_ack) state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_wdone) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, beat counter and valid bits; reset drops partial lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= 2'd0;
      valid <= '0;
    end else begin
      state <= state_nxt;
      if (fill_we) begin
        beat <= mem_rlast ? 2'd0 : beat + 2'd1;
        if (mem_rlast && !uncached) valid[idx] <= 1'b1;
      end
    end
  end

  // Data storage: refill beats, line tag on the last beat, store-hit merge.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      fill_buf[fill_idx] <= mem_rdata;
      if (!uncached) data_mem[idx][beat] <= mem_rdata;
      if (mem_rlast && !uncached) tag_mem[idx] <= tag;
    end
    if ((state == IDLE) && is_store && hit) begin
      data_mem[idx][word] <= byte_merge(data_mem[idx][word], ram_write_data, ram_select);
    end
  end

`ifndef SYNTHESIS
  // A cacheable burst must deliver all four words before its last beat.
  early_rlast: assert property (@(posedge clk) disable iff (rst)
    (fill_we && mem_rlast && !uncached) |-> (beat == 2'd3));
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: randomized bench for dcache_wt with a scoreboard of expected
// core responses and expected memory requests, built from a line-level model.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en, ram_read_en, ram_write_en;
  logic [3:0]  ram_select;
  logic [31:0] ram_addr, ram_write_data;
  logic        is_cache_hit;
  logic [31:0] ram_read_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack, mem_rvalid, mem_rlast, mem_wdone;
  logic [31:0] mem_rdata;

  dcache_wt dut (
    .clk(clk), .rst(rst), .ram_en(ram_en), .ram_read_en(ram_read_en),
    .ram_write_en(ram_write_en), .ram_select(ram_select), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .is_cache_hit(is_cache_hit),
    .ram_read_data(ram_read_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .mem_wdone(mem_wdone)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, req_cyc = 0, done_cnt = 0, beats_sent = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; bit hit; } resp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } mreq_t;
  resp_t exp_q[$];
  mreq_t mem_q[$];

  // Reference view (what the core should observe) and the memory the responder serves.
  logic [31:0] ref_mem  [int unsigned];
  logic [31:0] phys_mem [int unsigned];
  bit          mvalid [64];
  logic [21:0] mtag   [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] initw(input int unsigned w);
    logic [31:0] v;
    v = w;
    return {v[15:0] ^ 16'h5A5A, v[15:0]};
  endfunction

  function automatic logic [31:0] rd_ref(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : initw(w);
  endfunction

  function automatic logic [31:0] rd_phys(input int unsigned w);
    return phys_mem.exists(w) ? phys_mem[w] : initw(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit in_window(input logic [31:0] a);
`ifdef DCACHE_UNCACHED_WINDOW_EN
    return a[31:28] == 4'hB;
`else
    return a[31] & 1'b0;
`endif
  endfunction

  task automatic recover();
    rst = 1'b1;
    ram_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    exp_q.delete();
    mem_q.delete();
  endtask

  // Predict the outcome of one core request, issue it, and wait for completion.
  task automatic do_req(input bit re, input bit we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wd);
    int unsigned w;
    int          idx, n, target;
    logic [21:0] t;
    resp_t       r;
    mreq_t       m;
    w   = addr >> 2;
    idx = int'(addr[9:4]);
    t   = addr[31:10];
    if (we) begin
      ref_mem[w] = merge(rd_ref(w), wd, sel);
      r.data = 32'h0; r.hit = 1'b0;
      m.we = 1'b1; m.addr = addr; m.wdata = wd; m.wstrb = sel;
      mem_q.push_back(m);
    end else begin
      r.data = rd_ref(w);
      if (!in_window(addr) && mvalid[idx] && mtag[idx] == t) begin
        r.hit = 1'b1;
      end else begin
        r.hit = 1'b0;
        m.we = 1'b0; m.wdata = 32'h0; m.wstrb = 4'h0;
        m.addr = in_window(addr) ? {addr[31:2], 2'b00} : {addr[31:4], 4'b0000};
        mem_q.push_back(m);
        if (!in_window(addr)) begin
          mvalid[idx] = 1'b1;
          mtag[idx]   = t;
        end
      end
    end
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    ram_en = 1'b1; ram_read_en = re; ram_write_en = we;
    ram_select = sel; ram_addr = addr; ram_write_data = wd;
    req_cyc = cyc;
    target  = done_cnt + 1;
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) begin
      tests++; fails++;
      $display("FAIL req_timeout: addr %h got no completion, required one within 200 cycles", addr);
      recover();
    end
    ram_en = 1'b0; ram_read_en = 1'b0; ram_write_en = 1'b0;
  endtask

  // Monitor: every completed request is popped and compared.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst && is_cache_hit) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_hit: is_cache_hit=1 data %h, required no completion", ram_read_data);
        end else begin
          e = exp_q.pop_front();
          check("read_data", ram_read_data, e.data);
          check("same_cycle_hit", {31'b0, cyc == req_cyc}, {31'b0, e.hit});
        end
        done_cnt++;
      end
    end
  end

  // Memory responder: checks each request against the expected queue, then serves it.
  initial begin
    mreq_t m;
    int    nb;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_wdone = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req) begin
        if (mem_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_mem_req: we %0b addr %h, required no request", mem_we, mem_addr);
        end else begin
          m = mem_q.pop_front();
          check("mem_we", {31'b0, mem_we}, {31'b0, m.we});
          check("mem_addr", mem_addr, m.addr);
          if (m.we) begin
            check("mem_wdata", mem_wdata, m.wdata);
            check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, m.wstrb});
          end
        end
        m.we = mem_we; m.addr = mem_addr; m.wdata = mem_wdata; m.wstrb = mem_wstrb;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        if (m.we) begin
          phys_mem[m.addr >> 2] = merge(rd_phys(m.addr >> 2), m.wdata, m.wstrb);
          repeat (1 + $urandom_range(0, 2)) @(negedge clk);
          mem_wdone = 1'b1;
          @(posedge clk);
          #1 mem_wdone = 1'b0;
        end else begin
          nb = in_window(m.addr) ? 1 : 4;
          for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 1)) @(posedge clk);
            @(negedge clk);
            if (rst) break;
            mem_rvalid = 1'b1;
            mem_rdata  = rd_phys((m.addr >> 2) + b);
            mem_rlast  = (b == nb - 1);
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            beats_sent++;
          end
        end
      end
    end
  end

  initial begin
    int n;
    bit re, we;
    logic [31:0] a;
    mreq_t m;
    rst = 1'b1;
    ram_en = 1'b0; ram_read_en = 1'b0; ram_write_en = 1'b0;
    ram_select = 4'h0; ram_addr = 32'h0; ram_write_data = 32'h0;
    for (int i = 0; i < 64; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h400 + i]  = 32'h11 * (i + 1);
      phys_mem[32'h400 + i] = 32'h11 * (i + 1);
    end
    repeat (2) @(negedge clk);
    check("rst_hit", {31'b0, is_cache_hit}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_read_data", ram_read_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold fill, repeat hit, neighbour hit, partial store, reload.
    do_req(1, 0, 4'h0, 32'h0000_1004, 32'h0);
    do_req(1, 0, 4'h0, 32'h0000_1004, 32'h0);
    do_req(1, 0, 4'h0, 32'h0000_1008, 32'h0);
    do_req(0, 1, 4'b0011, 32'h0000_100C, 32'hAABB_CCDD);
    do_req(1, 0, 4'h0, 32'h0000_100C, 32'h0);
    // Conflict on index 0.
    do_req(1, 0, 4'h0, 32'h0000_2004, 32'h0);
    do_req(1, 0, 4'h0, 32'h0000_1004, 32'h0);

    // Reset in the middle of a refill.
    m.we = 1'b0; m.addr = 32'h0000_5010; m.wdata = 32'h0; m.wstrb = 4'h0;
    mem_q.push_back(m);
    @(posedge clk);
    #1;
    beats_sent = 0;
    ram_en = 1'b1; ram_read_en = 1'b1; ram_write_en = 1'b0; ram_addr = 32'h0000_5014;
    n = 0;
    while (beats_sent < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beats_before_reset", beats_sent, 2);
    #1 rst = 1'b1;
    #1;
    check("midfill_rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("midfill_rst_hit", {31'b0, is_cache_hit}, 32'h0);
    ram_en = 1'b0; ram_read_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    mem_q.delete();
    do_req(1, 0, 4'h0, 32'h0000_1004, 32'h0);
    do_req(1, 0, 4'h0, 32'h0000_1004, 32'h0);

`ifdef DCACHE_UNCACHED_WINDOW_EN
    do_req(1, 0, 4'h0, 32'hB000_0010, 32'h0);
    do_req(1, 0, 4'h0, 32'hB000_0010, 32'h0);
    do_req(0, 1, 4'hF, 32'hB000_0010, 32'h1234_5678);
    do_req(1, 0, 4'h0, 32'hB000_0010, 32'h0);
`endif

    // Both enables: store priority, then confirm the merged word.
    do_req(1, 1, 4'b1100, 32'h0000_1008, 32'hDEAD_BEEF);
    do_req(1, 0, 4'h0, 32'h0000_1008, 32'h0);

    // Randomized mix over a few tags and indices to provoke hits and conflicts.
    for (int k = 0; k < 200; k++) begin
      a = ($urandom_range(1, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
`ifdef DCACHE_UNCACHED_WINDOW_EN
      if ($urandom_range(0, 19) == 0) a = 32'hB000_0000 | (a & 32'hFFF);
`endif
      we = ($urandom_range(0, 9) < 4);
      re = we ? ($urandom_range(0, 9) == 0) : 1'b1;
      do_req(re, we, 4'($urandom_range(0, 15)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL leftover_expectations: resp %0d mem %0d, required 0 0", exp_q.size(), mem_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the CPU core's memory stage. It consumes the core's ram_* request bus and returns is_cache_hit / ram_read_data.
- Misses refill a full line from the memory-side burst bus. Stores are forwarded word-by-word to memory.
- The core pauses its MEM stage while ram_en=1 and is_cache_hit=0.

Parameters:
- INDEX_W, 6, line index bits (64 lines).
- OFFSET_W, 4, byte offset bits (16-byte line = 4 words). Fixed at 4.
- TAG_W, 22, tag bits. Must equal 32-INDEX_W-OFFSET_W.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- ram_en  in  1  core request valid
- ram_read_en  in  1  load request
- ram_write_en  in  1  store request
- ram_select  in  4  byte enables for the store
- ram_addr  in  32  byte address, word aligned
- ram_write_data  in  32  store data
- is_cache_hit  out  1  request complete this cycle; load data valid
- ram_read_data  out  32  load data
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = single-word write, 0 = 4-beat read burst
- mem_addr  out  32  line-aligned address for reads, word address for writes
- mem_wdata  out  32  write data
- mem_wstrb  out  4  write byte enables
- mem_ack  in  1  request accepted (handshake on mem_req && mem_ack)
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  32  read beat data
- mem_rlast  in  1  final beat of burst
- mem_wdone  in  1  write response

Behaviour:
- Reset: all valid bits cleared; FSM in IDLE; mem_req=0, mem_we=0, is_cache_hit=0, ram_read_data=0, beat counter=0.
- Storage: tag/valid/data arrays indexed by ram_addr[OFFSET_W+INDEX_W-1:OFFSET_W]; word select is ram_addr[3:2]. Reads are combinational (distributed RAM).
- IDLE, load: on ram_en && ram_read_en, a tag match with valid set gives is_cache_hit=1 combinationally in the same cycle, with ram_read_data = word. A miss goes to REFILL_REQ.
- IDLE, store: on ram_en && ram_write_en, is_cache_hit=0 and go to WR_REQ. On a tag hit, the cached word is byte-merged per ram_select on the cycle WR_REQ is entered.
- REFILL_REQ: mem_req=1, mem_we=0, mem_addr={ram_addr[31:4],4'b0}. On mem_ack go to REFILL.
- REFILL: each mem_rvalid writes mem_rdata into word[beat] and increments beat (2-bit, wraps). On the mem_rlast beat, write tag, set valid, and go to RESP.
- RESP: one cycle with is_cache_hit=1 and ram_read_data = the requested word (bypassed from the fill buffer), then IDLE.
- WR_REQ: mem_req=1, mem_we=1, mem_addr=ram_addr, mem_wdata=ram_write_data, mem_wstrb=ram_select. On mem_ack go to WR_WAIT.
- WR_WAIT: on mem_wdone go to RESP (is_cache_hit=1 for one cycle, ram_read_data=0), then IDLE.
- Core inputs are held stable by the core while is_cache_hit=0. The cache does not latch them, except the beat counter and the fill buffer.
- ram_read_en and ram_write_en both set: store has priority. ram_en=0 gives is_cache_hit=0.
- mem_rvalid outside REFILL is ignored. mem_rlast before 4 beats: the line is marked valid anyway (protocol violation; assert in simulation).
- Reset mid-refill: FSM returns to IDLE and all valid bits are cleared, so partial lines are never visible.
- ram_addr[1:0] is ignored.

Optional Feature:
- Macro DCACHE_UNCACHED_WINDOW_EN.
- When defined, loads with ram_addr[31:28]==4'hB bypass the cache: a single-beat read (mem_addr = word address, mem_rlast expected on the first beat). Data is returned via RESP; arrays and valid bits are untouched. Stores in the window skip the array merge.
- When undefined, all addresses are cacheable.

Test Plan:
- Cold load 0x0000_1004 -> REFILL_REQ with mem_addr=0x0000_1000. Beats 11,22,33,44 -> RESP with is_cache_hit=1 and ram_read_data=0x22. A repeat load gives a same-cycle hit returning 0x22.
- Load 0x0000_1008 after the fill -> hit, ram_read_data=0x33, mem_req stays 0.
- Store 0x0000_100C data 0xAABBCCDD, select 4'b0011 -> mem_wstrb=0011. After mem_wdone, a load of 0x100C returns 0x0000CCDD (old 0x44 upper bytes zero).
- Conflict: load 0x0000_2004 (same index, new tag) -> refill. A subsequent load of 0x1004 misses again.
- Assert rst during REFILL beat 2 -> IDLE, mem_req=0. A load of 0x1004 then misses.
- With DCACHE_UNCACHED_WINDOW_EN: load 0xB000_0010 twice -> two single-beat mem reads, no hit on the second.
